// File: rtl/expr_pipe_if.sv
// Handshake bundle for expr_pipe: operand input channel and result output channel.
// The producer/consumer side uses master, the pipeline itself uses slave.
interface expr_pipe_if #(
  parameter int W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [6*W-1:0]   in_data;
  logic             in_op;
  logic             out_valid;
  logic             out_ready;
  logic [2*W:0]     out_data;
  logic             out_dz;

  modport master (
    output in_valid, in_data, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_dz
  );

  modport slave (
    input  in_valid, in_data, in_op, out_ready,
    output in_ready, out_valid, out_data, out_dz
  );
endinterface

// File: rtl/expr_pipe.sv
// Three-stage valid/ready pipeline computing (a/b)*(c/d) -/+ (e/f) on unsigned operands,
// with divide-by-zero flagged rather than trapped, and a wrapping consumed-result counter.
module expr_pipe #(
  parameter int W     = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  expr_pipe_if.slave       bus,
  output logic [CNT_W-1:0] res_cnt
);

  localparam int DW = 6 * W;
  localparam int RW = 2 * W + 1;

  // Zero divisor saturates to all-ones; the caller reports it through the dz flag.
  function automatic logic [W-1:0] div_q(input logic [W-1:0] n, input logic [W-1:0] d);
    if (d == {W{1'b0}}) begin
      div_q = {W{1'b1}};
    end else begin
      div_q = n / d;
    end
  endfunction

  logic             r_v1;
  logic [DW-1:0]    r_data1;
  logic             r_op1;

  logic             r_v2;
  logic [W-1:0]     r_qab2;
  logic [W-1:0]     r_qcd2;
  logic [W-1:0]     r_qef2;
  logic             r_op2;
  logic             r_dz2;

  logic             r_v3;
  logic [2*W-1:0]   r_prod3;
  logic [W-1:0]     r_qef3;
  logic             r_op3;
  logic             r_dz3;

  logic [CNT_W-1:0] r_cnt;

  logic             w_ld1;
  logic             w_ld2;
  logic             w_ld3;
  logic [W-1:0]     w_a;
  logic [W-1:0]     w_b;
  logic [W-1:0]     w_c;
  logic [W-1:0]     w_d;
  logic [W-1:0]     w_e;
  logic [W-1:0]     w_f;
  logic [W-1:0]     w_qab;
  logic [W-1:0]     w_qcd;
  logic [W-1:0]     w_qef;
  logic             w_dz;
  logic [2*W-1:0]   w_prod;
  logic [RW-1:0]    w_prod_ext;
  logic [RW-1:0]    w_qef_ext;
  logic [RW-1:0]    w_res;

  // A stage may load when it is empty or its content moves on this same edge.
  assign w_ld3 = !r_v3 || bus.out_ready;
  assign w_ld2 = !r_v2 || w_ld3;
  assign w_ld1 = !r_v1 || w_ld2;

  assign bus.in_ready = w_ld1;

  assign w_a = r_data1[6*W-1:5*W];
  assign w_b = r_data1[5*W-1:4*W];
  assign w_c = r_data1[4*W-1:3*W];
  assign w_d = r_data1[3*W-1:2*W];
  assign w_e = r_data1[2*W-1:W];
  assign w_f = r_data1[W-1:0];

  assign w_qab = div_q(w_a, w_b);
  assign w_qcd = div_q(w_c, w_d);
  assign w_qef = div_q(w_e, w_f);
  assign w_dz  = (w_b == {W{1'b0}}) || (w_d == {W{1'b0}}) || (w_f == {W{1'b0}});

  assign w_prod = {{W{1'b0}}, r_qab2} * {{W{1'b0}}, r_qcd2};

  // Both terms are non-negative, so zero extension into the signed result width is exact.
  assign w_prod_ext = {1'b0, r_prod3};
  assign w_qef_ext  = {{(W+1){1'b0}}, r_qef3};

  // Final add/subtract from the S3 registers.
  always_comb begin
    w_res = {RW{1'b0}};
    if (r_op3) begin
      w_res = w_prod_ext + w_qef_ext;
    end else begin
      w_res = w_prod_ext - w_qef_ext;
    end
  end

  assign bus.out_valid = r_v3;
  assign bus.out_data  = w_res;
  assign bus.out_dz    = r_dz3;
  assign res_cnt       = r_cnt;

  // S1: capture operands and op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1    <= 1'b0;
      r_data1 <= {DW{1'b0}};
      r_op1   <= 1'b0;
    end else if (w_ld1) begin
      r_v1 <= bus.in_valid;
      if (bus.in_valid) begin
        r_data1 <= bus.in_data;
        r_op1   <= bus.in_op;
      end
    end
  end

  // S2: the three quotients plus the divide-by-zero flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v2   <= 1'b0;
      r_qab2 <= {W{1'b0}};
      r_qcd2 <= {W{1'b0}};
      r_qef2 <= {W{1'b0}};
      r_op2  <= 1'b0;
      r_dz2  <= 1'b0;
    end else if (w_ld2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_qab2 <= w_qab;
        r_qcd2 <= w_qcd;
        r_qef2 <= w_qef;
        r_op2  <= r_op1;
        r_dz2  <= w_dz;
      end
    end
  end

  // S3: exact product alongside the pending e/f term.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v3    <= 1'b0;
      r_prod3 <= {(2*W){1'b0}};
      r_qef3  <= {W{1'b0}};
      r_op3   <= 1'b0;
      r_dz3   <= 1'b0;
    end else if (w_ld3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_prod3 <= w_prod;
        r_qef3  <= r_qef2;
        r_op3   <= r_op2;
        r_dz3   <= r_dz2;
      end
    end
  end

  // Consumed-result counter, wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (r_v3 && bus.out_ready) begin
      r_cnt <= r_cnt + CNT_W'(1'b1);
    end
  end

endmodule

// File: tb/tb_expr_pipe.sv
// Self-checking bench for expr_pipe: directed vectors, back-pressure, random traffic
// against an integer-arithmetic reference model, and asynchronous reset.
module tb_expr_pipe;
  localparam int W     = 4;
  localparam int CNT_W = 16;
  localparam int RW    = 2 * W + 1;
  localparam int DW    = 6 * W;

  logic             clk = 1'b0;
  logic             reset;
  logic [CNT_W-1:0] res_cnt;

  expr_pipe_if #(.W(W)) bus ();

  expr_pipe #(.W(W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .res_cnt (res_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [RW:0] exp_q[$];

  // Reference: {dz, result} straight from the arithmetic definition.
  function automatic logic [RW:0] model(input logic [DW-1:0] d, input logic op);
    int v[6];
    int q[3];
    int r;
    int maxq;
    bit dz;
    logic [RW-1:0] rb;
    maxq = (1 << W) - 1;
    for (int i = 0; i < 6; i++) v[i] = int'(d[(5-i)*W +: W]);
    dz = (v[1] == 0) || (v[3] == 0) || (v[5] == 0);
    for (int k = 0; k < 3; k++) q[k] = (v[2*k+1] == 0) ? maxq : v[2*k] / v[2*k+1];
    r  = op ? q[0] * q[1] + q[2] : q[0] * q[1] - q[2];
    rb = r[RW-1:0];
    return {dz, rb};
  endfunction

  function automatic logic [DW-1:0] pack(input int a, input int b, input int c,
                                         input int d, input int e, input int f);
    return {a[W-1:0], b[W-1:0], c[W-1:0], d[W-1:0], e[W-1:0], f[W-1:0]};
  endfunction

  task automatic do_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_op     = 1'b0;
    bus.out_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_op     = 1'b0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      n_cmp++; if (bus.out_data !== '0) begin n_err++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
      n_cmp++; if (bus.out_dz !== 1'b0) begin n_err++; $display("FAIL reset_out_dz got=%b exp=0", bus.out_dz); end
      n_cmp++; if (res_cnt !== '0) begin n_err++; $display("FAIL reset_res_cnt got=%0d exp=0", res_cnt); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      // Inputs offered during reset must be ignored.
      bus.in_valid  = 1'b1;
      bus.in_data   = pack(1, 1, 1, 1, 1, 1);
      bus.out_ready = 1'b1;
      repeat (4) @(negedge clk);
    end
    do_reset();
  endtask

  task automatic test_vectors();
    int v[4][6] = '{'{12, 3, 8, 2, 10, 5}, '{12, 3, 8, 2, 10, 5},
                    '{15, 1, 15, 1, 15, 1}, '{1, 2, 3, 1, 15, 1}};
    logic op[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [RW-1:0] ev[4] = '{9'd14, 9'd18, 9'd240, 9'h1F1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = pack(v[i][0], v[i][1], v[i][2], v[i][3], v[i][4], v[i][5]);
      bus.in_op     = op[i];
      #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL vec%0d_in_ready got=%b exp=1", i, bus.in_ready); end
      @(negedge clk);
      bus.in_valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        if (c > 1) @(negedge clk);
        #1;
        n_cmp++;
        if (bus.out_valid !== (c == 3)) begin
          n_err++; $display("FAIL vec%0d_latency edge+%0d out_valid got=%b exp=%b", i, c - 1, bus.out_valid, c == 3);
        end
      end
      n_cmp++; if (bus.out_data !== ev[i]) begin n_err++; $display("FAIL vec%0d_data got=%h exp=%h", i, bus.out_data, ev[i]); end
      n_cmp++; if (bus.out_dz !== 1'b0) begin n_err++; $display("FAIL vec%0d_dz got=%b exp=0", i, bus.out_dz); end
    end
    @(negedge clk);
    #1;
    n_cmp++; if (res_cnt !== 16'd4) begin n_err++; $display("FAIL vec_res_cnt got=%0d exp=4", res_cnt); end
  endtask

  task automatic test_div_zero();
    logic [DW-1:0] d[2];
    logic [RW:0]   ex[2];
    int got;
    d[0]  = pack(5, 0, 1, 1, 0, 1);
    d[1]  = pack(12, 3, 8, 2, 10, 5);
    ex[0] = {1'b1, 9'd15};
    ex[1] = {1'b0, 9'd14};
    do_reset();
    bus.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 12 && got < 2; c++) begin
      @(negedge clk);
      bus.in_valid = (c < 2);
      bus.in_data  = d[c < 2 ? c : 1];
      bus.in_op    = 1'b0;
      #1;
      if (bus.out_valid) begin
        n_cmp++;
        if ({bus.out_dz, bus.out_data} !== ex[got]) begin
          n_err++; $display("FAIL divzero_%0d got dz=%b data=%h exp dz=%b data=%h", got, bus.out_dz, bus.out_data, ex[got][RW], ex[got][RW-1:0]);
        end
        n_cmp++; if (c != got + 3) begin n_err++; $display("FAIL divzero_%0d_timing got cycle=%0d exp=%0d", got, c, got + 3); end
        got++;
      end
    end
    n_cmp++; if (got != 2) begin n_err++; $display("FAIL divzero_count got=%0d exp=2", got); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] items[5];
    logic [RW-1:0] held;
    int idx;
    int got;
    logic acc;
    do_reset();
    for (int i = 0; i < 5; i++) items[i] = DW'($urandom);
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.in_valid = (idx < 5);
      bus.in_data  = items[idx < 5 ? idx : 4];
      bus.in_op    = items[idx < 5 ? idx : 4][0];
      #1;
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    n_cmp++; if (idx != 3) begin n_err++; $display("FAIL bp_accepted got=%0d exp=3", idx); end
    @(negedge clk);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
    held = bus.out_data;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== held) begin
        n_err++; $display("FAIL bp_stable got v=%b data=%h exp v=1 data=%h", bus.out_valid, bus.out_data, held);
      end
    end
    got = 0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = (idx < 5);
      bus.in_data   = items[idx < 5 ? idx : 4];
      bus.in_op     = items[idx < 5 ? idx : 4][0];
      #1;
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        n_cmp++;
        if ({bus.out_dz, bus.out_data} !== model(items[got], items[got][0])) begin
          n_err++; $display("FAIL bp_result_%0d got=%h exp=%h", got, {bus.out_dz, bus.out_data}, model(items[got], items[got][0]));
        end
        got++;
      end
      @(posedge clk);
      if (acc) idx++;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (got != 5) begin n_err++; $display("FAIL bp_drained got=%0d exp=5", got); end
    n_cmp++; if (res_cnt !== 16'd5) begin n_err++; $display("FAIL bp_res_cnt got=%0d exp=5", res_cnt); end
  endtask

  task automatic test_random();
    int sent;
    int got;
    logic r0;
    logic r1;
    logic acc;
    logic stall_prev;
    logic [RW:0] held;
    logic [RW:0] ex;
    do_reset();
    sent = 0;
    got = 0;
    stall_prev = 1'b0;
    held = '0;
    for (int c = 0; c < 20000 && got < 1000; c++) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = (sent >= 1000) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      r0 = bus.in_ready;
      bus.in_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
      bus.in_data  = DW'($urandom);
      bus.in_op    = 1'($urandom);
      #1;
      r1 = bus.in_ready;
      n_cmp++; if (r0 !== r1) begin n_err++; $display("FAIL rnd_ready_indep got=%b exp=%b", r1, r0); end
      if (stall_prev) begin
        n_cmp++;
        if (bus.out_valid !== 1'b1 || {bus.out_dz, bus.out_data} !== held) begin
          n_err++; $display("FAIL rnd_hold got v=%b val=%h exp v=1 val=%h", bus.out_valid, {bus.out_dz, bus.out_data}, held);
        end
      end
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        ex = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_cmp++;
        if ({bus.out_dz, bus.out_data} !== ex) begin
          n_err++; $display("FAIL rnd_result_%0d got=%h exp=%h", got, {bus.out_dz, bus.out_data}, ex);
        end
        got++;
      end
      if (acc) begin
        exp_q.push_back(model(bus.in_data, bus.in_op));
        sent++;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held = {bus.out_dz, bus.out_data};
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (got != 1000) begin n_err++; $display("FAIL rnd_timeout got=%0d exp=1000", got); end
    n_cmp++; if (res_cnt !== CNT_W'(got)) begin n_err++; $display("FAIL rnd_res_cnt got=%0d exp=%0d", res_cnt, got); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rnd_extra_output got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] d;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = DW'($urandom);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #1;
    n_cmp++; if (res_cnt !== 16'd2) begin n_err++; $display("FAIL arst_pre_cnt got=%0d exp=2", res_cnt); end
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre_valid got=%b exp=1", bus.out_valid); end
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL arst_out_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (res_cnt !== '0) begin n_err++; $display("FAIL arst_res_cnt got=%0d exp=0", res_cnt); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL arst_in_ready got=%b exp=1", bus.in_ready); end
    #1 reset = 1'b0;
    @(negedge clk);
    d = pack(9, 2, 7, 3, 4, 0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_op     = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      n_cmp++;
      if (bus.out_valid !== (c == 3)) begin
        n_err++; $display("FAIL arst_latency edge+%0d got=%b exp=%b", c - 1, bus.out_valid, c == 3);
      end
    end
    n_cmp++;
    if ({bus.out_dz, bus.out_data} !== model(d, 1'b1)) begin
      n_err++; $display("FAIL arst_result got=%h exp=%h", {bus.out_dz, bus.out_data}, model(d, 1'b1));
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_div_zero();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/expr_pipe.md
EXPR_PIPE -- requirements
Module: expr_pipe

Interface
REQ-001 The block SHALL have parameter W, default 4, legal 2..16: operand width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 16: width of the completed-result counter.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high, with ports named clk and reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high clear of all state.
REQ-006 in_valid  input  1  in_data and in_op are valid this cycle.
REQ-007 in_ready  output  1  the block accepts an input this cycle.
REQ-008 in_data  input  6W  operands {a,b,c,d,e,f}, with a in the MSBs; all unsigned.
REQ-009 in_op  input  1  0: out = (a/b)*(c/d) - (e/f); 1: out = (a/b)*(c/d) + (e/f).
REQ-010 out_valid  output  1  out_data and out_dz are valid.
REQ-011 out_ready  input  1  the consumer accepts the result this cycle.
REQ-012 out_data  output  2W+1  result, two's complement signed.
REQ-013 out_dz  output  1  at least one of b, d, f was zero for this result.
REQ-014 res_cnt  output  CNT_W  count of results consumed (out_valid&&out_ready).

Function
REQ-015 An input SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-016 The block SHALL be a 3-register pipeline:
  - S1 registers in_data, in_op.
  - S2 registers the three quotients a/b, c/d, e/f (W bits each), op, and the dz flag.
  - S3 registers the product (2W bits), the e/f quotient, op, and dz.
  - out_data SHALL be combinational from S3.
REQ-017 Each stage SHALL carry a valid bit and SHALL load when it is empty or its contents leave on the same edge; in_ready = !v1 || !v2 || !v3 || out_ready, evaluated as a chain (no bubble-only stall).
REQ-018 With out_ready held 1, throughput SHALL be one result per cycle; an input accepted at edge N SHALL give out_valid=1 after edge N+2.
REQ-019 Division SHALL be unsigned and truncating; a zero divisor SHALL yield quotient 2^W-1 and set dz; division by zero SHALL NOT stall or drop the transaction.
REQ-020 The product SHALL be exact (2W bits). The sum or difference SHALL be computed in 2W+1 signed bits, with no overflow possible over the full operand range.
REQ-021 While out_valid && !out_ready, out_data, out_dz and out_valid SHALL hold stable, and upstream stages SHALL fill bubbles and then stall.
REQ-022 Results SHALL leave in acceptance order, with no loss or duplication under any in_valid/out_ready pattern.
REQ-023 A simultaneous accept and emit in a full pipe SHALL advance all stages in one edge.
REQ-024 res_cnt SHALL increment by 1 per consumed result and wrap from 2^CNT_W-1 to 0.
REQ-025 in_ready SHALL NOT depend on in_valid.

Reset
REQ-026 While reset is high, out_valid, all stage valid bits, out_data, out_dz and res_cnt SHALL be 0, and in_ready SHALL be 1.
REQ-027 Asserting reset mid-operation SHALL discard all in-flight transactions immediately, without waiting for a clock edge.
REQ-028 The first input SHALL be accepted on the first rising edge after reset deasserts.

Verification (W=4)
REQ-029 a=12,b=3,c=8,d=2,e=10,f=5, op=0, out_ready=1 -> out_data=14, dz=0, out_valid exactly 2 edges after the accept edge.
REQ-030 Same operands with op=1 -> 18; then a=15,b=1,c=15,d=1,e=15,f=1, op=1 -> 240; a=1,b=2,c=3,d=1,e=15,f=1, op=0 -> -15 (9'h1F1).
REQ-031 a=5,b=0,c=1,d=1,e=0,f=1, op=0 -> out_data=15, out_dz=1; the next back-to-back transaction returns dz=0.
REQ-032 out_ready=0 while driving 5 back-to-back inputs -> 3 are accepted, then in_ready=0 and out_data is stable. Then out_ready=1 -> all 5 results emerge in order, res_cnt=5.
REQ-033 Random in_valid/out_ready at 50% over 1000 transactions against a reference model -> ordered, exact results, and res_cnt equals the number of results consumed.
REQ-034 reset pulse asserted between clock edges with 3 transactions in flight -> out_valid=0 and res_cnt=0 at once; the next input's result is correct with 2-edge latency.
